// File: rtl/music_player_sched_if.sv
// music_player_sched_if: requester, ROM and speaker signals of the shared-speaker song scheduler.
// Rev 1.0
`default_nettype none

interface music_player_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int NOTE_AW = 6
);
  logic [NUM_REQ-1:0]      req;
  logic                    stop;
  logic [ID_W+NOTE_AW-1:0] rom_addr;
  logic [15:0]             rom_data;
  logic [NUM_REQ-1:0]      grant;
  logic                    busy;
  logic                    done;
  logic                    speaker;

  modport master (
    output req, stop, rom_data,
    input  rom_addr, grant, busy, done, speaker
  );

  modport slave (
    input  req, stop, rom_data,
    output rom_addr, grant, busy, done, speaker
  );
endinterface

`default_nettype wire

// File: rtl/music_player_sched.sv
// music_player_sched: round-robin song scheduler walking a note ROM and driving a square-wave speaker.
// Rev 1.0 -- define MUSIC_GAP_EN to insert GAP_CYCLES of silence between notes.
`default_nettype none

module music_player_sched #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int NOTE_AW     = 6,
  parameter int BEAT_CYCLES = 1000,
  parameter int GAP_CYCLES  = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  music_player_sched_if.slave   bus
);

  localparam int DUR_W = 4 + $clog2(BEAT_CYCLES + 1);
  localparam logic [NOTE_AW-1:0] c_NOTE_MAX = {NOTE_AW{1'b1}};
`ifdef MUSIC_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
`ifdef MUSIC_GAP_EN
    S_GAP,
`endif
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [ID_W-1:0]         r_rr;
  logic [ID_W-1:0]         r_id;
  logic [NOTE_AW-1:0]      r_note;
  logic [ID_W+NOTE_AW-1:0] r_addr;
  logic [NUM_REQ-1:0]      r_grant;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_spk;
  logic [11:0]             r_hp;
  logic [11:0]             r_tone;
  logic [DUR_W-1:0]        r_dur;
`ifdef MUSIC_GAP_EN
  logic [GAP_W-1:0]        r_gap;
`endif

  logic                    w_found;
  logic [ID_W-1:0]         w_sel;
  logic [ID_W-1:0]         w_rr_next;
  logic [NOTE_AW-1:0]      w_note_inc;
  int                      w_idx;

  // First requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_rr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = ID_W'(w_idx);
      end
    end
  end

  assign w_rr_next  = (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
  assign w_note_inc = r_note + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_id    <= '0;
      r_note  <= '0;
      r_addr  <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_spk   <= 1'b0;
      r_hp    <= '0;
      r_tone  <= '0;
      r_dur   <= '0;
`ifdef MUSIC_GAP_EN
      r_gap   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (bus.stop && r_state != S_IDLE && r_state != S_DONE) begin
        r_state <= S_DONE;
        r_done  <= 1'b1;
        r_spk   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_found) begin
              r_grant <= NUM_REQ'(1) << w_sel;
              r_id    <= w_sel;
              r_note  <= '0;
              r_addr  <= {w_sel, {NOTE_AW{1'b0}}};
              r_rr    <= w_rr_next;
              r_busy  <= 1'b1;
              r_state <= S_FETCH;
            end
          end
          S_FETCH: r_state <= S_LOAD;
          S_LOAD: begin
            if (bus.rom_data[3:0] == 4'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_hp    <= bus.rom_data[15:4];
              r_tone  <= bus.rom_data[15:4] - 12'd1;
              r_dur   <= DUR_W'(bus.rom_data[3:0]) * DUR_W'(BEAT_CYCLES);
              r_state <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (r_dur == DUR_W'(1)) begin
              r_spk <= 1'b0;
              if (r_note == c_NOTE_MAX) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_note <= w_note_inc;
`ifdef MUSIC_GAP_EN
                r_gap   <= GAP_W'(GAP_CYCLES - 1);
                r_state <= S_GAP;
`else
                r_addr  <= {r_id, w_note_inc};
                r_state <= S_FETCH;
`endif
              end
            end else begin
              r_dur <= r_dur - 1'b1;
              if (r_tone == 12'd0) begin
                r_tone <= r_hp - 12'd1;
                if (r_hp != 12'd0) r_spk <= ~r_spk;
              end else begin
                r_tone <= r_tone - 12'd1;
              end
            end
          end
`ifdef MUSIC_GAP_EN
          S_GAP: begin
            if (r_gap == '0) begin
              r_addr  <= {r_id, r_note};
              r_state <= S_FETCH;
            end else begin
              r_gap <= r_gap - 1'b1;
            end
          end
`endif
          S_DONE: begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr = r_addr;
  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  // stop silences the pin in the same cycle it is raised.
  assign bus.speaker  = r_spk & ~bus.stop;

endmodule

`default_nettype wire
